barcode_tx: RTL and testbench

BARCODE_TX -- requirements
Module: barcode_tx

---
 rtl/barcode_tx_if.sv | 22 ++
 rtl/barcode_tx.sv | 109 ++++++++++
 tb/tb_barcode_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/barcode_tx_if.sv
// Barcode transmitter bus: request/configuration from the host, serial line
// and status back to it.
interface barcode_tx_if;
    logic        send;
    logic [7:0]  station_ID;
    logic [21:0] period;
    logic        BC;
    logic        busy;
    logic        done;

    // Host side: issues requests, watches the line and status.
    modport master (
        output send, station_ID, period,
        input  BC, busy, done
    );

    // Transmitter side.
    modport slave (
        input  send, station_ID, period,
        output BC, busy, done
    );
endinterface

// File: rtl/barcode_tx.sv
// Barcode transmitter: serialises an 8-bit station ID MSB first. Each bit
// occupies a window of P clocks, low for Q (bit '1') or 3*Q (bit '0') clocks
// and high for the remainder, where Q = P/4 and P is at least 16.
module barcode_tx (
    input  logic          clk,
    input  logic          rst,
    barcode_tx_if.slave   bus
);
    localparam logic [21:0] MIN_PERIOD = 22'd16;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t      state, state_next;
    logic [21:0] win_cnt, win_cnt_next;
    logic [21:0] p_len, p_len_next;
    logic [7:0]  shift, shift_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic        bc_q, bc_next;
    logic        done_q, done_next;

    logic [21:0] quarter;
    logic [21:0] low_len;

    // Q <= 2^20-1, so 3*Q still fits in 22 bits.
    assign quarter = p_len >> 2;
    assign low_len = shift[7] ? quarter : (quarter << 1) + quarter;

    assign bus.BC   = bc_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;

    // Next-state, datapath and registered-output decisions for the frame FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_next   = state;
        win_cnt_next = win_cnt;
        p_len_next   = p_len;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        bc_next      = 1'b1;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.send) begin
                    shift_next   = bus.station_ID;
                    p_len_next   = (bus.period < MIN_PERIOD) ? MIN_PERIOD : bus.period;
                    bit_cnt_next = 3'd0;
                    win_cnt_next = 22'd0;
                    state_next   = LOW;
                    bc_next      = 1'b0;
                end
            end

            LOW: begin
                win_cnt_next = win_cnt + 22'd1;
                bc_next      = 1'b0;
                if (win_cnt == low_len - 22'd1) begin
                    state_next = HIGH;
                    bc_next    = 1'b1;
                end
            end

            HIGH: begin
                win_cnt_next = win_cnt + 22'd1;
                if (win_cnt == p_len - 22'd1) begin
                    if (bit_cnt == 3'd7) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next   = LOW;
                        win_cnt_next = 22'd0;
                        shift_next   = {shift[6:0], 1'b0};
                        bit_cnt_next = bit_cnt + 3'd1;
                        bc_next      = 1'b0;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            win_cnt <= '0;
            p_len   <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            bc_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            win_cnt <= win_cnt_next;
            p_len   <= p_len_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            bc_q    <= bc_next;
            done_q  <= done_next;
        end
    end
endmodule

// File: tb/tb_barcode_tx.sv
// Self-checking bench for barcode_tx: a scoreboard of expected window
// low/high lengths and frame lengths, filled when a send is accepted and
// drained by a line monitor.
module tb_barcode_tx;
    typedef struct {
        int lo;
        int hi;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    barcode_tx_if bus ();

    barcode_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    win_t exp_win[$];
    int   exp_frame[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: expected windows and frame length for one accepted send.
    task automatic push_frame(input logic [7:0] id, input int per);
        int p, q;
        win_t w;
        p = (per < 16) ? 16 : per;
        q = p / 4;
        for (int i = 7; i >= 0; i--) begin
            w.lo = id[i] ? q : 3 * q;
            w.hi = p - w.lo;
            exp_win.push_back(w);
        end
        exp_frame.push_back(8 * p);
    endtask

    // Line monitor state.
    bit   prev_bc    = 1'b1;
    bit   prev_busy  = 1'b0;
    bit   in_frame   = 1'b0;
    bit   have_win   = 1'b0;
    int   lo_cnt     = 0;
    int   hi_cnt     = 0;
    int   frame_len  = 0;
    int   done_seen  = 0;

    task automatic emit_window();
        win_t w;
        if (exp_win.size() == 0) begin
            check("extra_window", 1, 0);
        end else begin
            w = exp_win.pop_front();
            check("win_low", lo_cnt, w.lo);
            check("win_high", hi_cnt, w.hi);
        end
    endtask

    // Measure each window and frame on the serial line, compare with scoreboard.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_seen++;
        if (bus.busy === 1'b1) begin
            if (bus.BC === 1'b0 && (prev_bc || !prev_busy)) begin
                if (have_win) emit_window();
                lo_cnt   = 1;
                hi_cnt   = 0;
                have_win = 1'b1;
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    frame_len = 0;
                end
            end else if (bus.BC === 1'b0) begin
                lo_cnt++;
            end else begin
                hi_cnt++;
            end
            frame_len++;
        end else if (in_frame) begin
            if (bus.done === 1'b1) begin
                emit_window();
                if (exp_frame.size() == 0) check("extra_frame", 1, 0);
                else check("frame_len", frame_len, exp_frame.pop_front());
                check("done_bc", bus.BC, 1'b1);
            end
            in_frame = 1'b0;
            have_win = 1'b0;
        end
        prev_bc   = (bus.BC === 1'b1);
        prev_busy = (bus.busy === 1'b1);
    end

    // Called at a negedge with the DUT idle: pulse send and check the 1-cycle latency.
    task automatic start_frame(input logic [7:0] id, input int per, input string tag);
        bus.station_ID = id;
        bus.period     = 22'(per);
        bus.send       = 1'b1;
        push_frame(id, per);
        @(negedge clk);
        bus.send = 1'b0;
        check({tag, "_bc_fall"}, bus.BC, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b1);
    endtask

    // Bounded wait for done; returns at the negedge of the done cycle.
    task automatic wait_done(input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int busy_cnt;
        bus.send       = 1'b0;
        bus.station_ID = 8'h00;
        bus.period     = 22'd0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_bc", bus.BC, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        @(negedge clk);

        // Mixed bits at the minimum period.
        start_frame(8'h2A, 16, "f2a");
        wait_done(8 * 16 + 10, "f2a");
        check("f2a_done_busy", bus.busy, 1'b0);
        @(negedge clk);

        // Period below minimum is clamped to 16.
        start_frame(8'hFF, 5, "fff");
        wait_done(8 * 16 + 10, "fff");
        @(negedge clk);

        // Long period, all zero bits.
        start_frame(8'h00, 1000, "f00");
        wait_done(8 * 1000 + 10, "f00");
        repeat (2) @(negedge clk);

        // Mid-frame send held with changed inputs is ignored; send in done cycle chains.
        start_frame(8'h5C, 20, "fmid");
        bus.station_ID = 8'hFF;
        bus.period     = 22'd16;
        bus.send       = 1'b1;
        repeat (30) @(negedge clk);
        bus.send = 1'b0;
        wait_done(8 * 20 + 10, "fmid");
        start_frame(8'h81, 16, "fb2b");
        wait_done(8 * 16 + 10, "fb2b");
        busy_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
        end
        check("no_extra_busy", busy_cnt, 0);

        // Reset in the third window aborts the frame without done.
        start_frame(8'hA5, 16, "fabort");
        repeat (36) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_bc", bus.BC, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        exp_win.delete();
        exp_frame.delete();
        done_seen = 0;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_seen, 0);
        check("abort_idle_bc", bus.BC, 1'b1);

        // Clean frame after the abort.
        start_frame(8'h3C, 24, "fpost");
        wait_done(8 * 24 + 10, "fpost");
        repeat (3) @(negedge clk);

        check("sb_win_empty", exp_win.size(), 0);
        check("sb_frame_empty", exp_frame.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
